// File: rtl/tx_mass_gen.sv
// Burst generator: collects a 5-byte command (mode, LEN) and emits ceil(LEN/BPB) beats.
// Optional mid-burst abort: define TX_MASS_GEN_ABORT_EN to add input i_abort.
module tx_mass_gen #(
    parameter int          TX_EW      = 2,
    parameter logic [7:0]  CONST_BYTE = 8'hA5,
    localparam int         BPB        = 1 << TX_EW,
    localparam int         DW         = 8 * BPB
) (
`ifdef TX_MASS_GEN_ABORT_EN
    input  logic          i_abort,
`endif
    input  logic          clk,
    input  logic          rstn,
    output logic          i_tready,
    input  logic          i_tvalid,
    input  logic [7:0]    i_tdata,
    input  logic          o_tready,
    output logic          o_tvalid,
    output logic [DW-1:0] o_tdata,
    output logic [BPB-1:0] o_tkeep,
    output logic          o_tlast
);

    typedef enum logic {CMD, SEND} state_t;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [BPB-1:0] keep;
        logic           last;
    } beat_t;

    state_t      state;
    logic [2:0]  byte_idx;
    logic [1:0]  mode;
    logic [23:0] len_lo;
    logic [31:0] rem;
    logic [7:0]  kbase;
    logic [31:0] lfsr;
    logic        abort_req;

    logic [31:0] len_full;
    logic [31:0] lfsr_nx;
    logic [31:0] rem_nx;
    logic [7:0]  k_nx;
    beat_t       load_beat;
    beat_t       next_beat;

    // Builds one beat from the remaining count, global byte index and LFSR state.
    function automatic beat_t make_beat(input logic [1:0] m, input logic [31:0] r,
                                        input logic [7:0] k, input logic [31:0] lf,
                                        input logic ab);
        beat_t      bt;
        logic       fin;
        logic [7:0] b;
        fin     = (r <= 32'(BPB));
        bt      = '0;
        bt.last = ab | fin;
        for (int unsigned j = 0; j < BPB; j++) begin
            bt.keep[j] = ab | ~fin | (j < r);
            case (m)
                2'd1:    b = lf[8*(j%4) +: 8];
                2'd2:    b = CONST_BYTE;
                default: b = k + 8'(j);
            endcase
            bt.data[8*j +: 8] = bt.keep[j] ? b : 8'h00;
        end
        return bt;
    endfunction

    assign i_tready = (state == CMD);

`ifdef TX_MASS_GEN_ABORT_EN
    logic abort_pend;
    assign abort_req = i_abort | abort_pend;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        len_full  = {i_tdata, len_lo};
        lfsr_nx   = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        rem_nx    = rem - 32'(BPB);
        k_nx      = kbase + 8'(BPB);
        load_beat = make_beat(mode, len_full, 8'h00, 32'hFFFF_FFFF, 1'b0);
        next_beat = make_beat(mode, rem_nx, k_nx, lfsr_nx, abort_req);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= CMD;
            byte_idx <= '0;
            mode     <= '0;
            len_lo   <= '0;
            rem      <= '0;
            kbase    <= '0;
            lfsr     <= '0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tkeep  <= '0;
            o_tlast  <= 1'b0;
`ifdef TX_MASS_GEN_ABORT_EN
            abort_pend <= 1'b0;
`endif
        end else begin
            case (state)
                CMD: begin
                    if (i_tvalid) begin
                        case (byte_idx)
                            3'd0:    mode          <= i_tdata[1:0];
                            3'd1:    len_lo[7:0]   <= i_tdata;
                            3'd2:    len_lo[15:8]  <= i_tdata;
                            3'd3:    len_lo[23:16] <= i_tdata;
                            default: ;
                        endcase
                        if (byte_idx == 3'd4) begin
                            byte_idx <= '0;
                            if (len_full != '0) begin
                                state    <= SEND;
                                rem      <= len_full;
                                kbase    <= '0;
                                lfsr     <= 32'hFFFF_FFFF;
                                o_tvalid <= 1'b1;
                                {o_tdata, o_tkeep, o_tlast} <= load_beat;
`ifdef TX_MASS_GEN_ABORT_EN
                                abort_pend <= 1'b0;
`endif
                            end
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                SEND: begin
                    if (o_tready) begin
                        // The presented beat carries tlast, so its transfer ends the burst.
                        if (o_tlast) begin
                            state    <= CMD;
                            o_tvalid <= 1'b0;
                            o_tdata  <= '0;
                            o_tkeep  <= '0;
                            o_tlast  <= 1'b0;
                        end else begin
                            rem   <= rem_nx;
                            kbase <= k_nx;
                            lfsr  <= lfsr_nx;
                            {o_tdata, o_tkeep, o_tlast} <= next_beat;
                        end
`ifdef TX_MASS_GEN_ABORT_EN
                        abort_pend <= 1'b0;
`endif
                    end
`ifdef TX_MASS_GEN_ABORT_EN
                    else begin
                        abort_pend <= abort_pend | i_abort;
                    end
`endif
                end
                default: state <= CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_mass_gen.sv
// Self-checking bench for tx_mass_gen (TX_EW=2): spec-level beat model plus directed commands.
module tb_tx_mass_gen;

    localparam int TX_EW = 2;
    localparam int BPB   = 1 << TX_EW;
    localparam int DW    = 8 * BPB;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [BPB-1:0] keep;
        logic           last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic           i_tready;
    logic           i_tvalid;
    logic [7:0]     i_tdata;
    logic           o_tready;
    logic           o_tvalid;
    logic [DW-1:0]  o_tdata;
    logic [BPB-1:0] o_tkeep;
    logic           o_tlast;
`ifdef TX_MASS_GEN_ABORT_EN
    logic           i_abort;
`endif

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    tx_mass_gen #(.TX_EW(TX_EW), .CONST_BYTE(8'hA5)) dut (
`ifdef TX_MASS_GEN_ABORT_EN
        .i_abort  (i_abort),
`endif
        .clk      (clk),
        .rstn     (rstn),
        .i_tready (i_tready),
        .i_tvalid (i_tvalid),
        .i_tdata  (i_tdata),
        .o_tready (o_tready),
        .o_tvalid (o_tvalid),
        .o_tdata  (o_tdata),
        .o_tkeep  (o_tkeep),
        .o_tlast  (o_tlast)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Expected beats of one command, straight from the byte-stream rules.
    task automatic model_cmd(input logic [7:0] mb, input logic [31:0] len);
        logic [31:0]     lf;
        logic [63:0]     dbl;
        longint unsigned nb;
        longint unsigned rem;
        beat_t           e;
        logic [7:0]      v;
        bit              on;
        lf = 32'hFFFF_FFFF;
        nb = (64'(len) + BPB - 1) / BPB;
        for (longint unsigned b = 0; b < nb; b++) begin
            rem    = 64'(len) - b * BPB;
            e      = '0;
            e.last = (rem <= BPB);
            dbl    = {lf, lf};
            for (int j = 0; j < BPB; j++) begin
                on = !e.last || (j < rem);
                case (mb[1:0])
                    2'd1:    v = dbl[8*j +: 8];
                    2'd2:    v = 8'hA5;
                    default: v = 8'((b * BPB) + j);
                endcase
                e.keep[j]         = on;
                e.data[8*j +: 8]  = on ? v : 8'h00;
            end
            exp_q.push_back(e);
            lf = lfsr_step(lf);
        end
    endtask

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rstn) begin
            check("i_tready_vs_o_tvalid", 64'(i_tready), 64'(!o_tvalid));
            if (o_tvalid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %h keep %h last %b, expected no beat",
                             o_tdata, o_tkeep, o_tlast);
                end else begin
                    check("beat", 64'({o_tdata, o_tkeep, o_tlast}), 64'(exp_q[0]));
                    if (o_tready) begin
                        obs_q.push_back({o_tdata, o_tkeep, o_tlast});
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t        = 0;
        i_tvalid = 1'b1;
        i_tdata  = b;
        while (!i_tready && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) fail_now("send_byte");
        tick();
        i_tvalid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] mb, input logic [31:0] len);
        model_cmd(mb, len);
        send_byte(mb);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        send_byte(len[23:16]);
        send_byte(len[31:24]);
    endtask

    task automatic wait_done(input string name, input bit stall);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !i_tready) && t < 5000) begin
            if (stall) o_tready = (t % 3) != 1;
            tick();
            t++;
        end
        o_tready = 1'b1;
        if (t >= 5000) fail_now(name);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_obs(input int n);
        int t;
        t = 0;
        while (obs_q.size() < n && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) fail_now("wait_obs");
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_i_tready"}, 64'(i_tready), 64'd1);
        check({name, "_o_tvalid"}, 64'(o_tvalid), 64'd0);
        check({name, "_o_tlast"},  64'(o_tlast),  64'd0);
        check({name, "_o_tdata"},  64'(o_tdata),  64'd0);
        check({name, "_o_tkeep"},  64'(o_tkeep),  64'd0);
    endtask

    initial begin
        rstn     = 1'b0;
        i_tvalid = 1'b0;
        i_tdata  = 8'h00;
        o_tready = 1'b1;
`ifdef TX_MASS_GEN_ABORT_EN
        i_abort  = 1'b0;
`endif
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Incrementing pattern, partial last beat
        obs_q.delete();
        send_cmd(8'h00, 32'd10);
        wait_done("inc10", 1'b0);
        check("inc10_nbeats", 64'(obs_q.size()), 64'd3);
        check("inc10_b0", 64'(obs_q[0]), 64'({32'h03020100, 4'hF, 1'b0}));
        check("inc10_b1", 64'(obs_q[1]), 64'({32'h07060504, 4'hF, 1'b0}));
        check("inc10_b2", 64'(obs_q[2]), 64'({32'h00000908, 4'h3, 1'b1}));

        // Zero length: no beats, parsing restarts at byte0
        obs_q.delete();
        send_cmd(8'h00, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("len0_i_tready", 64'(i_tready), 64'd1);
            tick();
        end
        check("len0_nbeats", 64'(obs_q.size()), 64'd0);
        send_cmd(8'h02, 32'd4);
        wait_done("const4", 1'b0);
        check("const4_nbeats", 64'(obs_q.size()), 64'd1);
        check("const4_b0", 64'(obs_q[0]), 64'({32'hA5A5A5A5, 4'hF, 1'b1}));
        check("const4_i_tready", 64'(i_tready), 64'd1);

        // LFSR pattern with a 5-cycle stall on beat 1
        obs_q.delete();
        send_cmd(8'h01, 32'd8);
        wait_obs(1);
        o_tready = 1'b0;
        repeat (5) tick();
        o_tready = 1'b1;
        wait_done("lfsr8", 1'b0);
        check("lfsr8_nbeats", 64'(obs_q.size()), 64'd2);
        check("lfsr8_b0", 64'(obs_q[0]), 64'({32'hFFFFFFFF, 4'hF, 1'b0}));
        check("lfsr8_b1", 64'(obs_q[1]), 64'({32'hFFFFFFFE, 4'hF, 1'b1}));

        // Reserved mode 3 behaves as incrementing; upper mode bits ignored
        obs_q.delete();
        send_cmd(8'h07, 32'd5);
        wait_done("mode3", 1'b0);
        check("mode3_b1", 64'(obs_q[1]), 64'({32'h00000004, 4'h1, 1'b1}));
        obs_q.delete();
        send_cmd(8'hFE, 32'd6);
        wait_done("const6", 1'b1);
        check("const6_b1", 64'(obs_q[1]), 64'({32'h0000A5A5, 4'h3, 1'b1}));

        // Byte-index wrap, exact-multiple length, irregular backpressure
        obs_q.delete();
        send_cmd(8'h00, 32'd260);
        wait_done("inc260", 1'b1);
        check("inc260_nbeats", 64'(obs_q.size()), 64'd65);
        check("inc260_last", 64'(obs_q[64]), 64'({32'h03020100, 4'hF, 1'b1}));
        obs_q.delete();
        send_cmd(8'h01, 32'd23);
        wait_done("lfsr23", 1'b1);

        // Reset mid-command discards the partial command
        send_byte(8'h02);
        send_byte(8'h40);
        send_byte(8'h00);
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst_cmd");
        tick();
        rstn = 1'b1;
        tick();
        obs_q.delete();
        send_cmd(8'h00, 32'd2);
        wait_done("inc2", 1'b0);
        check("inc2_b0", 64'(obs_q[0]), 64'({32'h00000100, 4'h3, 1'b1}));

        // Reset mid-burst discards the burst
        obs_q.delete();
        send_cmd(8'h01, 32'd40);
        wait_obs(2);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check_reset_outputs("rst_burst");
        tick();
        rstn = 1'b1;
        tick();
        obs_q.delete();
        send_cmd(8'h00, 32'd3);
        wait_done("inc3", 1'b0);
        check("inc3_b0", 64'(obs_q[0]), 64'({32'h00020100, 4'h7, 1'b1}));

`ifdef TX_MASS_GEN_ABORT_EN
        // Abort sampled while beat 2 transfers: beat 3 becomes final
        begin
            int t;
            obs_q.delete();
            send_cmd(8'h00, 32'h100);
            t = 0;
            while (!(obs_q.size() == 2 && o_tvalid) && t < 2000) begin
                tick();
                t++;
            end
            if (t >= 2000) fail_now("abort_wait");
            i_abort = 1'b1;
            exp_q[1].last = 1'b1;
            exp_q[1].keep = '1;
            while (exp_q.size() > 2) void'(exp_q.pop_back());
            tick();
            i_abort = 1'b0;
            wait_done("abort", 1'b0);
            check("abort_nbeats", 64'(obs_q.size()), 64'd4);
            check("abort_b3", 64'(obs_q[3]), 64'({32'h0F0E0D0C, 4'hF, 1'b1}));
        end
`endif

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
